rf_write_arbiter: RTL and testbench
===================================

// Module: rf_write_arbiter
// PURPOSE
//  Arbitrates the single regfile write port between the in-order writeback
//  stage (WB) and one long-latency unit (LU, e.g. mul/div or load miss).
//  Buffers LU results in a small FIFO and drains them in WB idle slots.
//  Keeps a 32-bit busy scoreboard that decode uses to stall on pending LU
//  destinations. Requests a pipeline stall when the LU path starves.
//  Sits between the WB stage / LU and the regfile write port.
// PARAMETERS
//  WIDTH        32  data width of regfile entries
//  QDEPTH       2   LU result FIFO entries (>=1)
//  STARVE_LIMIT 8   cycles a FIFO head may wait before stall_req asserts (>=1)
// PORTS
//  clk            in   1      clock; all state updates on posedge
//  sync_rst_n     in   1      synchronous reset, active low
//  wb_valid       in   1      WB result valid; never back-pressured
//  wb_addr        in   5      WB destination register
//  wb_data        in   WIDTH  WB result
//  lu_valid       in   1      LU result valid (valid/ready)
//  lu_ready       out  1      FIFO can accept LU result
//  lu_addr        in   5      LU destination register
//  lu_data        in   WIDTH  LU result
//  issue_valid    in   1      LU op issued this cycle; marks dest busy
//  issue_addr     in   5      LU op destination register
//  busy_mask      out  32     bit i = LU write to xi pending; bit 0 always 0
//  stall_req      out  1      ask pipeline to insert WB bubble
//  q_count        out  $clog2(QDEPTH+1)  FIFO occupancy
//  rf_write_enable out 1      regfile write enable
//  rf_write_addr  out  5      regfile write address
//  rf_write_data  out  WIDTH  regfile write data
// BEHAVIOUR
//  Reset (sync_rst_n=0 at posedge): FIFO empty, q_count=0, busy_mask=0,
//   age=0. While sync_rst_n=0: lu_ready=0, stall_req=0, rf_write_enable=0
//   (combinationally gated). Reset mid-operation discards queued LU results.
//  Write port (combinational, zero latency):
//   - wb_valid && wb_addr!=0 -> WB owns port (addr/data from WB).
//   - else if FIFO non-empty -> head drains: enable=1, head addr/data, pop.
//   - else enable=0, addr=0, data=0.
//   - WB to x0 counts as idle slot; FIFO may drain in that cycle.
//  LU handshake: lu_ready = (q_count<QDEPTH); transfer when lu_valid&&lu_ready.
//   lu_ready is not a function of lu_valid. Transfer to x0 is accepted and
//   dropped (not enqueued). Push and pop in the same cycle when full: pop
//   frees slot next cycle only (lu_ready uses registered count).
//  FIFO: in-order, pointers wrap mod QDEPTH; q_count never exceeds QDEPTH.
//  Scoreboard (posedge): issue_valid && issue_addr!=0 sets bit; FIFO pop
//   clears bit of popped addr. Same-cycle set and clear of same bit -> set.
//   Dropped x0 results touch nothing.
//  Starvation: age counts cycles FIFO non-empty and head not popped; resets
//   to 0 on pop or empty; saturates at STARVE_LIMIT.
//   stall_req = (age>=STARVE_LIMIT) || (q_count==QDEPTH). Pipeline answers
//   with wb_valid=0 next cycle; head then drains.
//  Illegal (SVA, no recovery): issue to an already busy reg; wb_valid to a
//   busy reg; lu transfer whose addr is not busy; lu_data/addr change while
//   lu_valid && !lu_ready.
// TESTING
//  1 Reset, WB only: wb x5=0xDEADBEEF -> same cycle rf_write_enable=1,
//    addr=5, data=0xDEADBEEF; busy_mask=0, stall_req=0.
//  2 Issue x7, LU x7=0x11 while WB busy 3 cycles -> queued (q_count=1),
//    busy_mask[7]=1; first WB-idle cycle writes x7=0x11, bit 7 clears next.
//  3 Fill FIFO (2 LU results, WB busy) -> lu_ready=0, stall_req=1; held
//    lu_valid data unchanged; after bubble, drain order preserved.
//  4 Continuous WB, 1 queued LU -> stall_req rises exactly STARVE_LIMIT=8
//    cycles after enqueue; drops the cycle after the head pops.
//  5 LU result to x0 and WB to x0 -> no enqueue, no busy bit, WB x0 slot
//    drains queued head; issue x3 same cycle as pop of x3 -> bit 3 stays 1.
//  6 sync_rst_n low with 2 queued, busy 0x88 -> next cycle q_count=0,
//    busy_mask=0, no regfile write during reset.

Source files
------------

// File: rtl/rf_write_arbiter.sv
// Shares the single regfile write port between in-order writeback and a buffered
// long-latency unit, with a pending-write scoreboard and a starvation stall request.
module rf_write_arbiter #(
    parameter int WIDTH        = 32,
    parameter int QDEPTH       = 2,
    parameter int STARVE_LIMIT = 8,
    localparam int CW          = $clog2(QDEPTH + 1),
    localparam int PW          = (QDEPTH > 1) ? $clog2(QDEPTH) : 1,
    localparam int AW          = $clog2(STARVE_LIMIT + 1)
) (
    input  logic             clk,
    input  logic             sync_rst_n,
    input  logic             wb_valid,
    input  logic [4:0]       wb_addr,
    input  logic [WIDTH-1:0] wb_data,
    input  logic             lu_valid,
    output logic             lu_ready,
    input  logic [4:0]       lu_addr,
    input  logic [WIDTH-1:0] lu_data,
    input  logic             issue_valid,
    input  logic [4:0]       issue_addr,
    output logic [31:0]      busy_mask,
    output logic             stall_req,
    output logic [CW-1:0]    q_count,
    output logic             rf_write_enable,
    output logic [4:0]       rf_write_addr,
    output logic [WIDTH-1:0] rf_write_data
);

    logic [4:0]       addr_mem_q [QDEPTH];
    logic [WIDTH-1:0] data_mem_q [QDEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [31:0]      busy_q, busy_d;
    logic [AW-1:0]    age_q, age_d;

    logic             wb_take;
    logic             fifo_nempty;
    logic             push;
    logic             pop;
    logic [4:0]       head_addr;
    logic [WIDTH-1:0] head_data;

    assign head_addr   = addr_mem_q[rd_ptr_q];
    assign head_data   = data_mem_q[rd_ptr_q];
    assign fifo_nempty = (count_q != '0);
    assign wb_take     = wb_valid && (wb_addr != 5'd0);

    // lu_ready looks only at the registered count, so a pop never frees a slot
    // for a push in the same cycle.
    assign lu_ready  = sync_rst_n && (count_q < CW'(QDEPTH));
    assign push      = lu_valid && lu_ready && (lu_addr != 5'd0);
    assign pop       = sync_rst_n && !wb_take && fifo_nempty;
    assign stall_req = sync_rst_n &&
                       ((age_q >= AW'(STARVE_LIMIT)) || (count_q == CW'(QDEPTH)));
    assign q_count   = count_q;
    assign busy_mask = busy_q;

    always_comb begin
        rf_write_enable = 1'b0;
        rf_write_addr   = 5'd0;
        rf_write_data   = '0;
        if (sync_rst_n) begin
            if (wb_take) begin
                rf_write_enable = 1'b1;
                rf_write_addr   = wb_addr;
                rf_write_data   = wb_data;
            end else if (fifo_nempty) begin
                rf_write_enable = 1'b1;
                rf_write_addr   = head_addr;
                rf_write_data   = head_data;
            end
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = (wr_ptr_q == PW'(QDEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
        if (pop)  rd_ptr_d = (rd_ptr_q == PW'(QDEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Set wins over clear so a re-issue to the register being drained stays busy.
    always_comb begin
        busy_d = busy_q;
        if (pop) busy_d[head_addr] = 1'b0;
        if (issue_valid && (issue_addr != 5'd0)) busy_d[issue_addr] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_comb begin
        age_d = age_q;
        if (!fifo_nempty || pop) age_d = '0;
        else if (age_q < AW'(STARVE_LIMIT)) age_d = age_q + AW'(1);
    end

    always_ff @(posedge clk) begin
        if (!sync_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            busy_q   <= '0;
            age_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            busy_q   <= busy_d;
            age_q    <= age_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem_q[wr_ptr_q] <= lu_addr;
            data_mem_q[wr_ptr_q] <= lu_data;
        end
    end

    // Protocol violations by the surrounding pipeline; there is no recovery.
    a_issue_not_busy: assert property (@(posedge clk) disable iff (!sync_rst_n)
        (issue_valid && issue_addr != 5'd0) |->
            (!busy_q[issue_addr] || (pop && head_addr == issue_addr)));
    a_wb_not_busy: assert property (@(posedge clk) disable iff (!sync_rst_n)
        (wb_valid && wb_addr != 5'd0) |-> !busy_q[wb_addr]);
    a_lu_dest_busy: assert property (@(posedge clk) disable iff (!sync_rst_n)
        (lu_valid && lu_ready && lu_addr != 5'd0) |-> busy_q[lu_addr]);
    a_lu_hold: assert property (@(posedge clk) disable iff (!sync_rst_n)
        (lu_valid && !lu_ready) |=> (lu_valid && $stable(lu_addr) && $stable(lu_data)));

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter: inputs change 1 ns after each rising edge,
// outputs are sampled 1 ns later, with expected values worked out by hand.
module tb_rf_write_arbiter;

    logic        clk = 1'b0;
    logic        sync_rst_n;
    logic        wb_valid;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        lu_valid;
    logic        lu_ready;
    logic [4:0]  lu_addr;
    logic [31:0] lu_data;
    logic        issue_valid;
    logic [4:0]  issue_addr;
    logic [31:0] busy_mask;
    logic        stall_req;
    logic [1:0]  q_count;
    logic        rf_write_enable;
    logic [4:0]  rf_write_addr;
    logic [31:0] rf_write_data;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    rf_write_arbiter #(.WIDTH(32), .QDEPTH(2), .STARVE_LIMIT(8)) dut (
        .clk             (clk),
        .sync_rst_n      (sync_rst_n),
        .wb_valid        (wb_valid),
        .wb_addr         (wb_addr),
        .wb_data         (wb_data),
        .lu_valid        (lu_valid),
        .lu_ready        (lu_ready),
        .lu_addr         (lu_addr),
        .lu_data         (lu_data),
        .issue_valid     (issue_valid),
        .issue_addr      (issue_addr),
        .busy_mask       (busy_mask),
        .stall_req       (stall_req),
        .q_count         (q_count),
        .rf_write_enable (rf_write_enable),
        .rf_write_addr   (rf_write_addr),
        .rf_write_data   (rf_write_data)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic wb(input logic v, input logic [4:0] a, input logic [31:0] d);
        wb_valid = v; wb_addr = a; wb_data = d;
    endtask

    task automatic lu(input logic v, input logic [4:0] a, input logic [31:0] d);
        lu_valid = v; lu_addr = a; lu_data = d;
    endtask

    task automatic iss(input logic v, input logic [4:0] a);
        issue_valid = v; issue_addr = a;
    endtask

    task automatic port(input string tag, input logic en, input logic [4:0] a, input logic [31:0] d);
        chk({tag, "_en"}, 64'(rf_write_enable), 64'(en));
        chk({tag, "_addr"}, 64'(rf_write_addr), 64'(a));
        chk({tag, "_data"}, 64'(rf_write_data), 64'(d));
    endtask

    initial begin
        sync_rst_n = 1'b0;
        wb(0, 0, 0); lu(0, 0, 0); iss(0, 0);
        tick(); tick();
        settle();
        chk("rst_qcount", 64'(q_count), 0);
        chk("rst_busy", 64'(busy_mask), 0);
        chk("rst_lu_ready", 64'(lu_ready), 0);
        chk("rst_stall", 64'(stall_req), 0);

        // 1: plain WB write, zero latency
        sync_rst_n = 1'b1;
        wb(1, 5, 32'hDEADBEEF);
        settle();
        port("t1_wb", 1, 5, 32'hDEADBEEF);
        chk("t1_busy", 64'(busy_mask), 0);
        chk("t1_stall", 64'(stall_req), 0);
        chk("t1_lu_ready", 64'(lu_ready), 1);

        // 2: one LU result queued behind WB, drains in first idle slot
        tick(); wb(1, 1, 32'h1); iss(1, 7);
        tick(); wb(1, 2, 32'h2); iss(0, 0); lu(1, 7, 32'h11);
        settle();
        chk("t2_busy_set", 64'(busy_mask), 64'h80);
        port("t2_wb_owns", 1, 2, 32'h2);
        tick(); wb(1, 3, 32'h3); lu(0, 0, 0);
        settle();
        chk("t2_qcount1", 64'(q_count), 1);
        port("t2_wb_still", 1, 3, 32'h3);
        tick(); wb(1, 4, 32'h4);
        tick(); wb(0, 0, 0);
        settle();
        port("t2_drain", 1, 7, 32'h11);
        chk("t2_busy_before_pop", 64'(busy_mask), 64'h80);
        tick();
        settle();
        chk("t2_qcount0", 64'(q_count), 0);
        chk("t2_busy_clear", 64'(busy_mask), 0);
        port("t2_idle", 0, 0, 0);

        // 3: fill the FIFO, hold a third result, drain in order after the bubble
        wb(1, 10, 32'hA); iss(1, 8);
        tick(); wb(1, 11, 32'hB); iss(1, 9); lu(1, 8, 32'h88);
        tick(); wb(1, 12, 32'hC); iss(1, 13); lu(1, 9, 32'h99);
        settle();
        chk("t3_q1", 64'(q_count), 1);
        chk("t3_ready_q1", 64'(lu_ready), 1);
        tick(); wb(1, 14, 32'hE); iss(0, 0); lu(1, 13, 32'hDD);
        settle();
        chk("t3_full", 64'(q_count), 2);
        chk("t3_ready_full", 64'(lu_ready), 0);
        chk("t3_stall_full", 64'(stall_req), 1);
        chk("t3_busy", 64'(busy_mask), 64'h2300);
        port("t3_wb", 1, 14, 32'hE);
        tick(); wb(0, 0, 0);
        settle();
        port("t3_pop8", 1, 8, 32'h88);
        chk("t3_ready_pop_full", 64'(lu_ready), 0);
        tick();
        settle();
        port("t3_pop9", 1, 9, 32'h99);
        chk("t3_ready_after", 64'(lu_ready), 1);
        chk("t3_stall_after", 64'(stall_req), 0);
        chk("t3_busy_after", 64'(busy_mask), 64'h2200);
        tick(); lu(0, 0, 0);
        settle();
        port("t3_pop13", 1, 13, 32'hDD);
        chk("t3_q_pushpop", 64'(q_count), 1);
        tick();
        settle();
        chk("t3_empty", 64'(q_count), 0);
        chk("t3_busy_empty", 64'(busy_mask), 0);

        // 4: starvation under continuous WB
        wb(1, 1, 32'h100); iss(1, 20);
        tick(); iss(0, 0); lu(1, 20, 32'h20);
        for (int k = 1; k <= 9; k++) begin
            tick(); lu(0, 0, 0);
            settle();
            chk($sformatf("t4_stall_c%0d", k), 64'(stall_req), (k == 9) ? 64'd1 : 64'd0);
        end
        tick(); wb(0, 0, 0);
        settle();
        port("t4_pop", 1, 20, 32'h20);
        chk("t4_stall_at_pop", 64'(stall_req), 1);
        tick();
        settle();
        chk("t4_stall_drop", 64'(stall_req), 0);
        chk("t4_busy", 64'(busy_mask), 0);

        // 5: x0 results dropped, WB to x0 drains, re-issue during pop keeps bit
        iss(1, 3);
        tick(); iss(0, 0); wb(1, 5, 32'h5); lu(1, 3, 32'h33);
        tick(); lu(1, 0, 32'hFF);
        settle();
        chk("t5_q1", 64'(q_count), 1);
        tick(); lu(0, 0, 0); wb(1, 0, 32'h55); iss(1, 3);
        settle();
        chk("t5_x0_dropped", 64'(q_count), 1);
        chk("t5_busy_no_x0", 64'(busy_mask), 64'h8);
        port("t5_x0_slot_drain", 1, 3, 32'h33);
        tick(); wb(0, 0, 0); iss(1, 7);
        settle();
        chk("t5_q0", 64'(q_count), 0);
        chk("t5_bit3_stays", 64'(busy_mask), 64'h8);

        // 6: reset with two queued results
        tick(); iss(0, 0); wb(1, 1, 32'h1); lu(1, 3, 32'h3);
        tick(); lu(1, 7, 32'h7);
        tick(); lu(0, 0, 0);
        settle();
        chk("t6_q2", 64'(q_count), 2);
        chk("t6_busy", 64'(busy_mask), 64'h88);
        wb(0, 0, 0); sync_rst_n = 1'b0;
        settle();
        chk("t6_rst_no_write", 64'(rf_write_enable), 0);
        chk("t6_rst_ready", 64'(lu_ready), 0);
        chk("t6_rst_stall", 64'(stall_req), 0);
        tick();
        settle();
        chk("t6_q_cleared", 64'(q_count), 0);
        chk("t6_busy_cleared", 64'(busy_mask), 0);
        wb(1, 5, 32'h5A);
        settle();
        chk("t6_rst_wb_gated", 64'(rf_write_enable), 0);
        sync_rst_n = 1'b1;
        settle();
        port("t6_after_rst", 1, 5, 32'h5A);
        tick(); wb(0, 0, 0);
        settle();
        port("t6_idle", 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
